// File: rtl/xunit_sha256_round.sv
// SHA-256 compression unit: one round per cycle over an external W_t stream,
// followed by the chaining-value add that produces the registered 8-word digest.
module xunit_sha256_round #(
  parameter int DELAY_W = 7,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  h_in0,
  input  logic [DATA_W-1:0]  h_in1,
  input  logic [DATA_W-1:0]  h_in2,
  input  logic [DATA_W-1:0]  h_in3,
  input  logic [DATA_W-1:0]  h_in4,
  input  logic [DATA_W-1:0]  h_in5,
  input  logic [DATA_W-1:0]  h_in6,
  input  logic [DATA_W-1:0]  h_in7,
  input  logic [DELAY_W-1:0] delay0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {IDLE, WAIT, ROUND, FINAL} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t             state, state_next;
  logic [DATA_W-1:0]  v   [8];   // working variables a..h
  logic [DATA_W-1:0]  dig [8];
  logic [DATA_W-1:0]  h_in [8];
  logic [5:0]         round;
  logic [DELAY_W-1:0] delay;
  logic [DATA_W-1:0]  s0, s1, ch, maj, t1, t2;

  assign h_in[0] = h_in0;
  assign h_in[1] = h_in1;
  assign h_in[2] = h_in2;
  assign h_in[3] = h_in3;
  assign h_in[4] = h_in4;
  assign h_in[5] = h_in5;
  assign h_in[6] = h_in6;
  assign h_in[7] = h_in7;

  assign out0 = dig[0];
  assign out1 = dig[1];
  assign out2 = dig[2];
  assign out3 = dig[3];
  assign out4 = dig[4];
  assign out5 = dig[5];
  assign out6 = dig[6];
  assign out7 = dig[7];
  assign dbg_state = state;

  always_comb begin
    s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
    ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
    t1  = v[7] + s1 + ch + K[round] + in0;
    s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
    maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
    t2  = s0 + maj;
  end

  // run overrides everything, including running=0
  always_comb begin
    state_next = state;
    if (run) begin
      state_next = (delay0 == '0) ? ROUND : WAIT;
    end else if (running) begin
      case (state)
        WAIT:    if (delay == DELAY_W'(1)) state_next = ROUND;
        ROUND:   if (round == 6'd63) state_next = FINAL;
        FINAL:   state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        v[i]   <= '0;
        dig[i] <= '0;
      end
      round <= '0;
      delay <= '0;
      done  <= 1'b1;
    end else if (run) begin
      for (int i = 0; i < 8; i++) v[i] <= h_in[i];
      delay <= delay0;
      round <= '0;
      done  <= 1'b0;
    end else if (running) begin
      case (state)
        WAIT: delay <= delay - DELAY_W'(1);
        ROUND: begin
          v[7]  <= v[6];
          v[6]  <= v[5];
          v[5]  <= v[4];
          v[4]  <= v[3] + t1;
          v[3]  <= v[2];
          v[2]  <= v[1];
          v[1]  <= v[0];
          v[0]  <= t1 + t2;
          round <= round + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) dig[i] <= h_in[i] + v[i];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xunit_sha256_round.sv
// Directed bench for xunit_sha256_round: known-answer digests and done latency
// tracked by an expected queue, plus abort, reset and stall scenarios.
module tb_xunit_sha256_round;

  logic        clk = 1'b0;
  logic        rst, running, run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] h_in0, h_in1, h_in2, h_in3, h_in4, h_in5, h_in6, h_in7;
  logic [6:0]  delay0;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [1:0]  dbg_state;
  logic [255:0] dig_bus;

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  xunit_sha256_round #(.DELAY_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done), .in0(in0),
    .h_in0(h_in0), .h_in1(h_in1), .h_in2(h_in2), .h_in3(h_in3),
    .h_in4(h_in4), .h_in5(h_in5), .h_in6(h_in6), .h_in7(h_in7),
    .delay0(delay0),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .dbg_state(dbg_state)
  );

  assign dig_bus = {out0, out1, out2, out3, out4, out5, out6, out7};

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] exp_q[$];
  int           cyc_q[$];
  logic [31:0]  w_cur [64];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // single-block messages only need W0 and W15 set before expansion
  task automatic load_block(input logic [31:0] m0, input logic [31:0] m15);
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) w_cur[i] = 32'h0;
    w_cur[0]  = m0;
    w_cur[15] = m15;
    for (int t = 16; t < 64; t++) begin
      a = rotr(w_cur[t-2], 17) ^ rotr(w_cur[t-2], 19) ^ (w_cur[t-2] >> 10);
      b = rotr(w_cur[t-15], 7) ^ rotr(w_cur[t-15], 18) ^ (w_cur[t-15] >> 3);
      w_cur[t] = a + w_cur[t-7] + b + w_cur[t-16];
    end
  endtask

  // driver: pulse run, wait d cycles, stream W; optional stall or early abort
  task automatic run_block(input int d, input logic [255:0] exp, input int stall_at,
                           input int stall_len, input int abort_at);
    @(posedge clk); #1;
    run    = 1'b1;
    delay0 = 7'(d);
    if (abort_at < 0) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 1 + d + 65 + stall_len);
    end
    @(posedge clk); #1;
    run = 1'b0;
    in0 = $urandom;
    repeat (d) begin
      @(posedge clk); #1;
      in0 = $urandom;
    end
    for (int t = 0; t < 64; t++) begin
      if (t == abort_at) return;
      if (t == stall_at) begin
        running = 1'b0;
        repeat (stall_len) begin
          in0 = $urandom;
          @(posedge clk); #1;
        end
        running = 1'b1;
      end
      in0 = w_cur[t];
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, k);
    end
  endtask

  // monitor: every rising done (outside reset) must match the queue head
  initial begin
    logic prev_done;
    logic [255:0] e;
    int ec;
    prev_done = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b1;
      end else begin
        if (done && !prev_done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_digest: got %h with nothing expected", dig_bus);
          end else begin
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            check("digest", dig_bus, e);
            check("done_latency", 256'(cyc), 256'(ec));
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; running = 1'b1; in0 = '0; delay0 = '0;
    h_in0 = 32'h6a09e667; h_in1 = 32'hbb67ae85; h_in2 = 32'h3c6ef372; h_in3 = 32'ha54ff53a;
    h_in4 = 32'h510e527f; h_in5 = 32'h9b05688c; h_in6 = 32'h1f83d9ab; h_in7 = 32'h5be0cd19;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 256'(done), 256'(1));
    check("reset_out", dig_bus, 256'h0);
    check("reset_state", 256'(dbg_state), 256'(0));
    rst = 1'b0;

    // abc, no delay
    load_block(32'h61626380, 32'h00000018);
    run_block(0, DIG_ABC, -1, 0, -1);
    wait_done();

    // abc, W stream delayed 5 cycles
    run_block(5, DIG_ABC, -1, 0, -1);
    wait_done();

    // empty message
    load_block(32'h80000000, 32'h00000000);
    run_block(0, DIG_EMPTY, -1, 0, -1);
    wait_done();

    // abort at round 30, restart with abc
    load_block(32'h61626380, 32'h00000018);
    run_block(0, '0, -1, 0, 30);
    check("abort_out_held", dig_bus, DIG_EMPTY);
    check("abort_done_low", 256'(done), 256'(0));
    run_block(0, DIG_ABC, -1, 0, -1);
    wait_done();

    // reset at round 40, then a clean abc
    run_block(0, '0, -1, 0, 40);
    rst = 1'b1;
    #1;
    check("midrst_done", 256'(done), 256'(1));
    check("midrst_out", dig_bus, 256'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_block(0, DIG_ABC, -1, 0, -1);
    wait_done();

    // running low for 10 cycles at round 20
    run_block(0, DIG_ABC, 20, 10, -1);
    wait_done();

    repeat (3) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
